microsequencer_legv8: RTL and testbench

- Parametrised microcoded control sequencer for the LEGv8 datapath; next generation of the fixed 8-state control-word selector.
- State 0 is the built-in instruction-fetch word; states 1..NUM_STATES-1 take decoder-supplied control words.
- Next state comes from a field inside the current control word, qualified by a condition-code field and status flags.
- Adds stall, halt/resume, illegal-state recovery and a retired-fetch counter.

---
 rtl/microsequencer_legv8.sv | 98 +++++++++
 tb/tb_microsequencer_legv8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer_legv8.sv
// Microcoded control sequencer for the LEGv8 datapath.
// State 0 issues a built-in fetch word; every other state issues the
// decoder-supplied word for that state. Each word carries its own successor
// (next-state field) and a condition code that qualifies or halts it.
module microsequencer_legv8 #(
  parameter int CW_LENGTH   = 40,
  parameter int STATE_BITS  = 3,
  parameter int NUM_STATES  = 8,
  parameter int NS_LSB      = 34,
  parameter int COND_LSB    = 37,
  parameter logic [CW_LENGTH-1:0] FETCH_CW =
    40'b000_001_1_11_00_0_0_1_0_00000_0_11_0_0_00000_00000_00000,
  parameter logic [CW_LENGTH-1:0] STALL_MASK = '0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [(NUM_STATES-1)*CW_LENGTH-1:0]  cw_in,
  input  logic [4:0]                           status,
  input  logic                                 stall,
  input  logic                                 resume,
  output logic [CW_LENGTH-1:0]                 control_word,
  output logic [STATE_BITS-1:0]                state,
  output logic                                 halted,
  output logic                                 illegal_state,
  output logic [COUNT_WIDTH-1:0]               fetch_count
);

  localparam int DEPTH = 2**STATE_BITS;
  // One extra bit so NUM_STATES == 2**STATE_BITS is representable.
  localparam logic [STATE_BITS:0] NUM_S = NUM_STATES[STATE_BITS:0];

  localparam logic [2:0] COND_HALT = 3'd6;

  // Word table indexed directly by the state register. Entries at or beyond
  // NUM_STATES (only reachable through a fault) fall back to the fetch word.
  logic [CW_LENGTH-1:0] words [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    if (k > 0 && k < NUM_STATES) begin : g_dec
      assign words[k] = cw_in[(k-1)*CW_LENGTH +: CW_LENGTH];
    end else begin : g_fetch
      assign words[k] = FETCH_CW;
    end
  end

  logic [CW_LENGTH-1:0]  raw_cw;
  logic [2:0]            cond;
  logic [STATE_BITS-1:0] ns;
  logic [STATE_BITS-1:0] tgt;
  logic [STATE_BITS-1:0] nxt;
  logic [7:0]            status_x;
  logic                  take;
  logic                  state_ok;
  logic                  set_ill;

  assign raw_cw   = words[state];
  assign cond     = raw_cw[COND_LSB +: 3];
  assign ns       = raw_cw[NS_LSB +: STATE_BITS];
  assign status_x = {3'b000, status};
  assign state_ok = ({1'b0, state} < NUM_S);

  assign control_word = stall ? (raw_cw & ~STALL_MASK) : raw_cw;
  assign halted       = (cond == COND_HALT) & ~resume;

  // Next-state selection: fault recovery, then halt hold, then range check,
  // then the condition-qualified branch (failed condition returns to fetch).
  always_comb begin
    take    = 1'b1;
    set_ill = 1'b0;
    if (cond inside {[3'd1:3'd5]}) take = status_x[cond - 3'd1];
    tgt = take ? ns : '0;
    if (!state_ok) begin
      nxt = '0;
    end else if (cond == COND_HALT && !resume) begin
      nxt = state;
    end else if ({1'b0, tgt} >= NUM_S) begin
      nxt     = '0;
      set_ill = 1'b1;
    end else begin
      nxt = tgt;
    end
  end

  // State, sticky illegal flag and fetch counter; stall freezes all three.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= '0;
      illegal_state <= 1'b0;
      fetch_count   <= '0;
    end else if (!stall) begin
      state <= nxt;
      if (set_ill) illegal_state <= 1'b1;
      if (state == '0) fetch_count <= fetch_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_microsequencer_legv8.sv
// Scoreboard bench for microsequencer_legv8: a stimulus process advances an
// abstract model and queues the expected outputs of each cycle; a monitor
// process pops and compares them against the DUT on the falling edge.
module tb_microsequencer_legv8;

  localparam int NS  = 6;
  localparam int CWL = 40;
  localparam int CNW = 4;
  localparam logic [39:0] FETCH =
    40'b000_001_1_11_00_0_0_1_0_00000_0_11_0_0_00000_00000_00000;
  localparam logic [39:0] MASK = 40'h00000_0000F;

  logic                    clock;
  logic                    reset;
  logic [(NS-1)*CWL-1:0]   cw_in;
  logic [4:0]              status;
  logic                    stall;
  logic                    resume;
  logic [CWL-1:0]          control_word;
  logic [2:0]              state;
  logic                    halted;
  logic                    illegal_state;
  logic [CNW-1:0]          fetch_count;

  microsequencer_legv8 #(
    .CW_LENGTH(CWL), .STATE_BITS(3), .NUM_STATES(NS), .NS_LSB(34),
    .COND_LSB(37), .FETCH_CW(FETCH), .STALL_MASK(MASK), .COUNT_WIDTH(CNW)
  ) dut (
    .clock(clock), .reset(reset), .cw_in(cw_in), .status(status),
    .stall(stall), .resume(resume), .control_word(control_word),
    .state(state), .halted(halted), .illegal_state(illegal_state),
    .fetch_count(fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] cw;
    int          st;
    bit          h;
    bit          ill;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Abstract model state: integer state number, sticky flag, fetch count.
  int ms = 0;
  bit mf = 0;
  int mc = 0;
  logic [(NS-1)*CWL-1:0] next_cw = '0;

  function automatic logic [39:0] word_of(int s);
    if (s == 0 || s >= NS) return FETCH;
    return cw_in[(s-1)*CWL +: CWL];
  endfunction

  function automatic logic [39:0] mk(int c, int n);
    logic [39:0] w;
    w[31:0]  = $urandom;
    w[39:32] = 8'($urandom);
    w[39:37] = c[2:0];
    w[36:34] = n[2:0];
    return w;
  endfunction

  task automatic set_word(int k, int c, int n);
    next_cw[(k-1)*CWL +: CWL] = mk(c, n);
  endtask

  task automatic chk(string nm, logic [39:0] act, logic [39:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
    end
  endtask

  // One clock cycle: apply the rules of the edge to the model using the
  // inputs the DUT saw, then drive the next cycle's inputs and queue what
  // the DUT should show during that cycle.
  task automatic step(bit r, bit s, bit rs, logic [4:0] st);
    logic [39:0] w;
    int c, n, t;
    exp_t e;
    @(posedge clock);
    if (reset) begin
      ms = 0; mf = 0; mc = 0;
    end else if (!stall) begin
      w = word_of(ms);
      c = int'(w[39:37]);
      n = int'(w[36:34]);
      if (ms == 0) mc = (mc + 1) % (1 << CNW);
      if (ms >= NS) ms = 0;
      else if (!(c == 6 && !resume)) begin
        t = n;
        if (c >= 1 && c <= 5 && status[c-1] == 1'b0) t = 0;
        if (t >= NS) begin t = 0; mf = 1; end
        ms = t;
      end
    end
    #1;
    cw_in  = next_cw;
    reset  = r;
    stall  = s;
    resume = rs;
    status = st;
    if (r) begin ms = 0; mf = 0; mc = 0; end
    w     = word_of(ms);
    e.cw  = s ? (w & ~MASK) : w;
    e.st  = ms;
    e.h   = (w[39:37] == 3'd6) && !rs;
    e.ill = mf;
    e.cnt = mc;
    q.push_back(e);
  endtask

  task automatic run(int n, logic [4:0] st);
    for (int i = 0; i < n; i++) step(0, 0, 0, st);
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("control_word", control_word, e.cw);
        chk("state", 40'(state), 40'(e.st));
        chk("halted", 40'(halted), 40'(e.h));
        chk("illegal_state", 40'(illegal_state), 40'(e.ill));
        chk("fetch_count", 40'(fetch_count), 40'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; resume = 1'b0; status = '0; cw_in = '0;

    // Free run 0 -> 1 -> 2 -> 0 -> 1
    for (int k = 1; k < NS; k++) set_word(k, 0, 0);
    set_word(1, 0, 2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    run(6, 0);

    // Conditional branch on status[2]: taken, then not taken
    set_word(1, 3, 4);
    set_word(4, 0, 0);
    step(1, 0, 0, 0);
    run(6, 5'b00100);
    run(5, 5'b00000);

    // Halt in state 2 with resume low, then a one-cycle resume pulse
    set_word(1, 0, 2);
    set_word(2, 6, 3);
    set_word(3, 0, 0);
    step(1, 0, 0, 0);
    run(8, 0);
    step(0, 0, 1, 0);
    run(4, 0);

    // Out-of-range next state sets the sticky flag until reset
    set_word(1, 0, 7);
    step(1, 0, 0, 0);
    run(13, 0);
    step(1, 0, 0, 0);
    run(3, 0);

    // Stall for three cycles while in state 1
    set_word(1, 0, 2);
    set_word(2, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run(5, 0);

    // Counter wrap over 17 fetches, then reset asserted between edges
    set_word(1, 0, 0);
    step(1, 0, 0, 0);
    run(35, 0);
    step(1, 0, 0, 0);
    run(3, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0)
        for (int k = 1; k < NS; k++) set_word(k, $urandom_range(0, 7), $urandom_range(0, 7));
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 40), 5'($urandom));
    end

    repeat (4) @(negedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
